// File: rtl/issue_scoreboard_ctrl.sv
// Issue control beside ID: per-register busy scoreboard for RAW/WAW stalls,
// fixed-length flush after a taken branch, and a saturating stall counter.
module issue_scoreboard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter bit WB_BYPASS    = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_uses_rs2,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             kill_valid,
    input  logic [4:0]       kill_rd,
    input  logic             branch_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             issue_valid,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] stall_count
);

    // Pulse cycle counts as the first flush cycle, so load one less.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [31:0] busy;
    logic [31:0] clr;
    logic [31:0] set;
    logic [31:0] eff_busy;
    logic [2:0]  flush_cnt;
    logic        hazard;
    logic        flushing;

    // Registers retiring (writeback) or squashed (kill) this cycle.
    always_comb begin
        clr = ({31'b0, wb_valid} << wb_rd) | ({31'b0, kill_valid} << kill_rd);
        eff_busy = WB_BYPASS ? (busy & ~clr) : busy;
    end

    // Hazard check and issue decision; a flush overrides a stall.
    always_comb begin
        hazard = id_valid &&
                 (((id_rs1 != 5'd0) && eff_busy[id_rs1]) ||
                  (id_uses_rs2 && (id_rs2 != 5'd0) && eff_busy[id_rs2]) ||
                  (id_reg_write && (id_rd != 5'd0) && eff_busy[id_rd]));
        flushing    = (flush_cnt != 3'd0) || branch_taken;
        issue_valid = id_valid && !hazard && !flushing;
        stall_if    = hazard && !flushing;
        stall_id    = hazard && !flushing;
        bubble_ex   = !issue_valid;
        flush_if_id = flushing;
        set         = {31'b0, issue_valid && id_reg_write} << id_rd;
        busy_vec    = busy;
    end

    // Scoreboard: clear retiring/killed bits, then set the issuing rd; x0 never busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= '0;
        else        busy <= ((busy & ~clr) | set) & ~32'h1;
    end

    // Flush sequencer: a branch (re)loads, otherwise count down to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 flush_cnt <= '0;
        else if (branch_taken)      flush_cnt <= FLUSH_LOAD;
        else if (flush_cnt != 3'd0) flush_cnt <= flush_cnt - 3'd1;
    end

    // Saturating count of hazard-stall cycles for perf debug.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            stall_count <= '0;
        else if (stall_id && stall_count != '1) stall_count <= stall_count + 1'b1;
    end

endmodule
